// File: rtl/axi_pkg.sv
// Shared helpers for the AXI ID remapper wrappers.
package axi_pkg;

    function automatic int cnt_width(input int max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/axi_id_alloc_ctrl_lzc.sv
// Trailing-zero counter: index of the lowest set bit, empty when no bit is set.
module axi_id_alloc_ctrl_lzc #(
    parameter int Width = 4,
    parameter int IdxW  = 2
) (
    input  logic [Width-1:0] vec,
    output logic [IdxW-1:0]  idx,
    output logic             empty
);

    always_comb begin
        idx   = '0;
        empty = 1'b1;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IdxW'(i);
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_id_alloc_ctrl.sv
// ID allocation table for one remap direction: maps wide master IDs onto narrow
// slave IDs, keeping one slot per in-flight master ID to preserve same-ID ordering.
module axi_id_alloc_ctrl
    import axi_pkg::*;
#(
    parameter int IdWidthIn    = 4,
    parameter int IdWidthOut   = 2,
    parameter int TableSize    = 4,
    parameter int MaxTxnsPerId = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [IdWidthIn-1:0]  push_id_i,
    output logic [IdWidthOut-1:0] push_oup_id_o,
    input  logic                  pop_valid_i,
    input  logic [IdWidthOut-1:0] pop_oup_id_i,
    output logic [IdWidthIn-1:0]  pop_inp_id_o,
    output logic                  busy_o,
    output logic                  full_o
);

    localparam int IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;
    localparam int CntW = cnt_width(MaxTxnsPerId);

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef struct packed {
        logic [IdWidthIn-1:0] inp_id;
        cnt_t                 cnt;
    } entry_t;

    localparam cnt_t                  MaxCnt   = cnt_t'(MaxTxnsPerId);
    localparam logic [IdWidthOut:0]   NumSlots = (IdWidthOut + 1)'(TableSize);

    if (TableSize < 1 || TableSize > 2 ** IdWidthOut) begin : g_bad_table_size
        $fatal(1, "axi_id_alloc_ctrl: TableSize must be in 1..2**IdWidthOut");
    end

    entry_t [TableSize-1:0] tbl_q;
    logic   [TableSize-1:0] used, hit_vec, push_sel, pop_sel;
    idx_t                   hit_idx, free_idx, sel_idx, pop_idx;
    logic                   hit, no_free, push_fire, pop_idx_ok, pop_fire;

    always_comb begin
        used    = '0;
        hit_vec = '0;
        for (int i = 0; i < TableSize; i++) begin
            used[i]    = (tbl_q[i].cnt != '0);
            hit_vec[i] = used[i] && (tbl_q[i].inp_id == push_id_i);
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = TableSize - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = idx_t'(i);
        end
    end

    axi_id_alloc_ctrl_lzc #(
        .Width (TableSize),
        .IdxW  (IdxW)
    ) i_free_lzc (
        .vec   (~used),
        .idx   (free_idx),
        .empty (no_free)
    );

    assign hit    = |hit_vec;
    assign busy_o = |used;
    assign full_o = &used;

    // Lookup depends only on registered state, never on push_valid_i.
    always_comb begin
        sel_idx       = hit ? hit_idx : free_idx;
        push_ready_o  = hit ? (tbl_q[hit_idx].cnt < MaxCnt) : !no_free;
        push_oup_id_o = (hit || !no_free) ? IdWidthOut'(sel_idx) : '0;
    end

    assign push_fire  = push_valid_i && push_ready_o;
    assign pop_idx_ok = ({1'b0, pop_oup_id_i} < NumSlots);
    assign pop_idx    = idx_t'(pop_oup_id_i);
    // Illegal pops are dropped so the counter can never wrap.
    assign pop_fire   = pop_valid_i && pop_idx_ok && (tbl_q[pop_idx].cnt != '0);

    assign pop_inp_id_o = pop_idx_ok ? tbl_q[pop_idx].inp_id : '0;

    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        for (int i = 0; i < TableSize; i++) begin
            push_sel[i] = push_fire && (sel_idx == idx_t'(i));
            pop_sel[i]  = pop_fire && (pop_idx == idx_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_q <= '0;
        end else begin
            for (int i = 0; i < TableSize; i++) begin
                if (push_sel[i] && !pop_sel[i]) begin
                    tbl_q[i].cnt    <= tbl_q[i].cnt + cnt_t'(1);
                    tbl_q[i].inp_id <= push_id_i;
                end else if (pop_sel[i] && !push_sel[i]) begin
                    tbl_q[i].cnt <= tbl_q[i].cnt - cnt_t'(1);
                end
            end
        end
    end

    a_single_hit : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(hit_vec))
        else $error("axi_id_alloc_ctrl: more than one slot holds the same input ID");

    a_legal_pop : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_valid_i |-> (pop_idx_ok && tbl_q[pop_idx].cnt != '0))
        else $error("axi_id_alloc_ctrl: pop of an empty or out-of-range slot");

endmodule
